transcodor: RTL and testbench

Display transcoder downstream of the SRAM memory stage. Accepts each byte read back from SRAM with a one-cycle valid strobe and converts it to digit codes, as hex or as decimal depending on build. Drives a 4-digit, common-anode, multiplexed 7-segment display with a programmable refresh scan. Flags bytes that arrive while a conversion is in progress.

---
 rtl/transcodor_if.sv | 22 ++
 rtl/transcodor.sv | 142 ++++++++++++++
 tb/tb_transcodor.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/transcodor_if.sv
// Byte handshake between the SRAM read stage and the display transcoder.
// The master drives bytes in; the slave reports busy and the sticky drop flag.
interface transcodor_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       busy;
  logic       dropped;

  modport master (
    output data_in,
    output data_valid,
    input  busy,
    input  dropped
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output busy,
    output dropped
  );
endinterface

// File: rtl/transcodor.sv
// SRAM byte to 4-digit multiplexed 7-segment transcoder (common anode, active-low).
// Define TRANSCODOR_DEC_EN for decimal (double-dabble) conversion; otherwise hex with 2-byte history.
module transcodor #(
  parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
  input  logic         clk,
  input  logic         rst_n,
  transcodor_if.slave  bus,
  output logic [6:0]   seg,
  output logic [3:0]   an,
  output logic         dp
);

  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  state_t      state;
  logic        dropped;
  logic [3:0]  digit [4];
  logic [15:0] refresh_cnt;
  logic [1:0]  idx;

`ifdef TRANSCODOR_DEC_EN
  localparam logic [3:0] BLANK_MASK = 4'b1000;

  // Shift register layout: {hundreds, tens, units, remaining binary bits}
  logic [19:0] shreg;
  logic [19:0] shreg_adj;
  logic [2:0]  iter;

  always_comb begin
    shreg_adj = shreg;
    for (int i = 0; i < 3; i++) begin
      if (shreg[8+4*i +: 4] >= 4'd5)
        shreg_adj[8+4*i +: 4] = shreg[8+4*i +: 4] + 4'd3;
    end
  end
`else
  localparam logic [3:0] BLANK_MASK = 4'b0000;

  logic [7:0] cap_byte;
`endif

  function automatic logic [6:0] font(input logic [3:0] v);
    case (v)
      4'h0: font = 7'h40;
      4'h1: font = 7'h79;
      4'h2: font = 7'h24;
      4'h3: font = 7'h30;
      4'h4: font = 7'h19;
      4'h5: font = 7'h12;
      4'h6: font = 7'h02;
      4'h7: font = 7'h78;
      4'h8: font = 7'h00;
      4'h9: font = 7'h10;
      4'hA: font = 7'h08;
      4'hB: font = 7'h03;
      4'hC: font = 7'h46;
      4'hD: font = 7'h21;
      4'hE: font = 7'h06;
      default: font = 7'h0E;
    endcase
  endfunction

  assign bus.busy    = (state != IDLE);
  assign bus.dropped = dropped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dropped <= 1'b0;
      for (int i = 0; i < 4; i++) digit[i] <= 4'd0;
`ifdef TRANSCODOR_DEC_EN
      shreg   <= '0;
      iter    <= '0;
`else
      cap_byte <= '0;
`endif
    end else begin
      if (bus.data_valid && state != IDLE)
        dropped <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.data_valid) begin
`ifdef TRANSCODOR_DEC_EN
            shreg <= {12'd0, bus.data_in};
            iter  <= '0;
            state <= CONV;
`else
            cap_byte <= bus.data_in;
            state    <= LOAD;
`endif
          end
        end
`ifdef TRANSCODOR_DEC_EN
        CONV: begin
          shreg <= shreg_adj << 1;
          iter  <= iter + 3'd1;
          if (iter == 3'd7)
            state <= LOAD;
        end
`endif
        LOAD: begin
`ifdef TRANSCODOR_DEC_EN
          digit[2] <= shreg[19:16];
          digit[1] <= shreg[15:12];
          digit[0] <= shreg[11:8];
`else
          digit[3] <= digit[1];
          digit[2] <= digit[0];
          digit[1] <= cap_byte[7:4];
          digit[0] <= cap_byte[3:0];
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Display outputs follow the digit selected before the counter wraps, so each anode holds REFRESH_DIV cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      idx         <= '0;
      seg         <= 7'h7F;
      an          <= 4'hF;
      dp          <= 1'b1;
    end else begin
      if (refresh_cnt == REFRESH_DIV - 16'd1) begin
        refresh_cnt <= '0;
        idx         <= idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 16'd1;
      end
      an  <= ~(4'b0001 << idx);
      seg <= BLANK_MASK[idx] ? 7'h7F : font(digit[idx]);
      dp  <= ~((idx == 2'd0) & dropped);
    end
  end

endmodule

// File: tb/tb_transcodor.sv
// Self-checking bench for transcodor: a byte-level display model checked every cycle,
// plus hand-computed segment patterns for each directed byte sequence.
module tb_transcodor;

  localparam int DIV = 4;
`ifdef TRANSCODOR_DEC_EN
  localparam int LAT = 9;
  localparam bit DEC = 1'b1;
`else
  localparam int LAT = 1;
  localparam bit DEC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;

  int checks   = 0;
  int failures = 0;

  transcodor_if bus ();

  transcodor #(.REFRESH_DIV(16'd4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  always #5 clk = ~clk;

  logic [6:0] font_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: the digit values the display should hold and how long the current byte stays busy
  int         m_digit [4];
  bit         m_blank [4];
  int         m_busy_left = 0;
  int         m_pending   = 0;
  int         m_edges     = 0;
  bit         m_dropped   = 1'b0;
  logic [6:0] m_seg = 7'h7F;
  logic [3:0] m_an  = 4'hF;
  logic       m_dp  = 1'b1;

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_digit[i] = 0;
      m_blank[i] = 1'b0;
    end
    m_blank[3] = DEC;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_digit[i] = 0;
      m_busy_left = 0;
      m_edges     = 0;
      m_dropped   = 1'b0;
      m_seg       = 7'h7F;
      m_an        = 4'hF;
      m_dp        = 1'b1;
    end else begin
      int sel;
      m_edges = m_edges + 1;
      sel  = ((m_edges - 1) / DIV) % 4;
      m_an  = ~(4'b0001 << sel);
      m_seg = m_blank[sel] ? 7'h7F : font_tab[m_digit[sel]];
      m_dp  = !(sel == 0 && m_dropped);
      if (m_busy_left > 0) begin
        if (bus.data_valid) m_dropped = 1'b1;
        m_busy_left = m_busy_left - 1;
        if (m_busy_left == 0) begin
          if (DEC) begin
            m_digit[2] = m_pending / 100;
            m_digit[1] = (m_pending / 10) % 10;
            m_digit[0] = m_pending % 10;
          end else begin
            m_digit[3] = m_digit[1];
            m_digit[2] = m_digit[0];
            m_digit[1] = m_pending / 16;
            m_digit[0] = m_pending % 16;
          end
        end
      end else if (bus.data_valid) begin
        m_busy_left = LAT;
        m_pending   = int'(bus.data_in);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle, the DUT must agree with the model
  initial begin
    forever begin
      @(negedge clk);
      checkOutput("model_busy",    32'(bus.busy),    32'(m_busy_left > 0));
      checkOutput("model_dropped", 32'(bus.dropped), 32'(m_dropped));
      checkOutput("model_an",      32'(an),          32'(m_an));
      checkOutput("model_seg",     32'(seg),         32'(m_seg));
      checkOutput("model_dp",      32'(dp),          32'(m_dp));
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk); #1;
    bus.data_in    = b;
    bus.data_valid = 1'b1;
    @(negedge clk); #1;
    bus.data_valid = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput({name, "_idle_timeout"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic checkDigit(input int pos, input logic [6:0] exp_seg, input logic exp_dp, input string name);
    int  n;
    bit  found;
    found = 1'b0;
    for (n = 0; n < 40 && !found; n++) begin
      @(negedge clk);
      if (an == ~(4'b0001 << pos)) found = 1'b1;
    end
    if (!found) begin
      checkOutput({name, "_an_timeout"}, 32'(an), 32'(~(4'b0001 << pos)));
    end else begin
      checkOutput({name, "_seg"}, 32'(seg), 32'(exp_seg));
      checkOutput({name, "_dp"},  32'(dp),  32'(exp_dp));
    end
  endtask

  task automatic checkBusyLength(input logic [7:0] b, input string name);
    int n;
    applyStimulus(b);
    n = 0;
    while (bus.busy === 1'b1 && n < 30) begin
      n++;
      @(negedge clk); #1;
    end
    checkOutput(name, 32'(n), 32'(LAT));
  endtask

  logic [3:0] an_seq [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  initial begin
    bus.data_in    = 8'h00;
    bus.data_valid = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_seg",     32'(seg),         32'h7F);
    checkOutput("rst_an",      32'(an),          32'hF);
    checkOutput("rst_dp",      32'(dp),          32'd1);
    checkOutput("rst_busy",    32'(bus.busy),    32'd0);
    checkOutput("rst_dropped", 32'(bus.dropped), 32'd0);

    #1 rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkOutput("scan_an", 32'(an), 32'(an_seq[i/4]));
      if (i == 0) checkOutput("first_seg", 32'(seg), 32'h40);
    end

    $display("[TB] conversion sequence");
`ifdef TRANSCODOR_DEC_EN
    checkBusyLength(8'd255, "busy_len_255");
    checkDigit(3, 7'h7F, 1'b1, "d255_d3");
    checkDigit(2, 7'h24, 1'b1, "d255_d2");
    checkDigit(1, 7'h12, 1'b1, "d255_d1");
    checkDigit(0, 7'h12, 1'b1, "d255_d0");
    checkBusyLength(8'd7, "busy_len_7");
    checkDigit(2, 7'h40, 1'b1, "d7_d2");
    checkDigit(1, 7'h40, 1'b1, "d7_d1");
    checkDigit(0, 7'h78, 1'b1, "d7_d0");
`else
    checkBusyLength(8'hA5, "busy_len_A5");
    checkDigit(1, 7'h08, 1'b1, "hA5_d1");
    checkDigit(0, 7'h12, 1'b1, "hA5_d0");
    checkBusyLength(8'h3C, "busy_len_3C");
    checkDigit(3, 7'h08, 1'b1, "h3C_d3");
    checkDigit(2, 7'h12, 1'b1, "h3C_d2");
    checkDigit(1, 7'h30, 1'b1, "h3C_d1");
    checkDigit(0, 7'h46, 1'b1, "h3C_d0");
`endif

    $display("[TB] drop while busy");
    @(negedge clk); #1;
    bus.data_in    = 8'd100;
    bus.data_valid = 1'b1;
    for (int g = 1; g < (DEC ? 3 : 1); g++) begin
      @(negedge clk); #1;
      bus.data_valid = 1'b0;
    end
    @(negedge clk); #1;
    bus.data_in    = 8'd200;
    bus.data_valid = 1'b1;
    @(negedge clk); #1;
    bus.data_valid = 1'b0;
    waitIdle("drop");
    checkOutput("drop_flag", 32'(bus.dropped), 32'd1);
`ifdef TRANSCODOR_DEC_EN
    checkDigit(2, 7'h79, 1'b1, "d100_d2");
    checkDigit(1, 7'h40, 1'b1, "d100_d1");
    checkDigit(0, 7'h40, 1'b0, "d100_d0");
`else
    checkDigit(3, 7'h30, 1'b1, "h64_d3");
    checkDigit(2, 7'h46, 1'b1, "h64_d2");
    checkDigit(1, 7'h02, 1'b1, "h64_d1");
    checkDigit(0, 7'h19, 1'b0, "h64_d0");
`endif

    $display("[TB] reset mid-conversion");
    applyStimulus(8'd99);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy",    32'(bus.busy),    32'd0);
    checkOutput("midrst_dropped", 32'(bus.dropped), 32'd0);
    checkOutput("midrst_an",      32'(an),          32'hF);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    checkDigit(0, 7'h40, 1'b1, "postrst_d0");
    checkDigit(3, DEC ? 7'h7F : 7'h40, 1'b1, "postrst_d3");

    checkBusyLength(8'd42, "busy_len_42");
`ifdef TRANSCODOR_DEC_EN
    checkDigit(2, 7'h40, 1'b1, "d42_d2");
    checkDigit(1, 7'h19, 1'b1, "d42_d1");
    checkDigit(0, 7'h24, 1'b1, "d42_d0");
`else
    checkDigit(2, 7'h40, 1'b1, "h2A_d2");
    checkDigit(1, 7'h24, 1'b1, "h2A_d1");
    checkDigit(0, 7'h08, 1'b1, "h2A_d0");
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
